fetch_instruction: RTL and testbench

FETCH_INSTRUCTION -- requirements
Module: fetch_instruction

---
 rtl/fetch_instruction_if.sv | 26 ++
 rtl/fetch_instruction.sv | 126 ++++++++++++
 tb/tb_fetch_instruction.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_instruction_if.sv
// Fetch-unit bus: decode-side control (stall/branch), instruction-memory port and decode output.
// The master modport is the fetch unit itself; slave is the surrounding pipeline/memory.
interface fetch_instruction_if #(
  parameter int WORD = 32,
  parameter int ADDR = 32
);
  logic            stall_i;
  logic            branch_i;
  logic [ADDR-1:0] branch_pc_i;
  logic            imem_en_o;
  logic [ADDR-1:0] imem_addr_o;
  logic [WORD-1:0] imem_data_i;
  logic [WORD-1:0] inst_o;
  logic [ADDR-1:0] pc_o;
  logic            v_o;

  modport master (
    input  stall_i, branch_i, branch_pc_i, imem_data_i,
    output imem_en_o, imem_addr_o, inst_o, pc_o, v_o
  );

  modport slave (
    output stall_i, branch_i, branch_pc_i, imem_data_i,
    input  imem_en_o, imem_addr_o, inst_o, pc_o, v_o
  );
endinterface

// File: rtl/fetch_instruction.sv
// Instruction fetch: issue-to-valid latency 2 cycles, one instruction per cycle; decode stall holds the output register.
// Macro FETCH_SKID_EN adds a 1-entry skid so stall release has no bubble; without it the in-flight fetch is rewound and replayed.
module fetch_instruction #(
  parameter int              WORD     = 32,
  parameter int              ADDR     = 32,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 reset,
  fetch_instruction_if.master bus
);

  logic [ADDR-1:0] r_fetch_pc;
  logic            r_ifl_v;
  logic [ADDR-1:0] r_ifl_pc;
  logic            r_v;
  logic [WORD-1:0] r_inst;
  logic [ADDR-1:0] r_pc;

  logic            w_issue;
  logic [ADDR-1:0] w_fetch_pc_nx;
  logic            w_ifl_v_nx;
  logic [ADDR-1:0] w_ifl_pc_nx;
  logic            w_v_nx;
  logic [WORD-1:0] w_inst_nx;
  logic [ADDR-1:0] w_pc_nx;

`ifdef FETCH_SKID_EN
  logic            r_sk_v;
  logic [WORD-1:0] r_sk_inst;
  logic [ADDR-1:0] r_sk_pc;
  logic            w_sk_v_nx;
  logic [WORD-1:0] w_sk_inst_nx;
  logic [ADDR-1:0] w_sk_pc_nx;
`endif

  // No issue while stalled, so at most one fetch can be in flight when a stall begins.
  assign w_issue         = ~reset & ~bus.stall_i & ~bus.branch_i;
  assign bus.imem_en_o   = w_issue;
  assign bus.imem_addr_o = r_fetch_pc;
  assign bus.v_o         = r_v;
  assign bus.inst_o      = r_inst;
  assign bus.pc_o        = r_pc;

  always_comb begin
    w_fetch_pc_nx = r_fetch_pc;
    w_ifl_v_nx    = 1'b0;
    w_ifl_pc_nx   = r_ifl_pc;
    w_v_nx        = r_v;
    w_inst_nx     = r_inst;
    w_pc_nx       = r_pc;
`ifdef FETCH_SKID_EN
    w_sk_v_nx     = r_sk_v;
    w_sk_inst_nx  = r_sk_inst;
    w_sk_pc_nx    = r_sk_pc;
`endif

    if (bus.branch_i) begin
      // Redirect beats stall: everything fetched so far is on the wrong path.
      w_fetch_pc_nx = bus.branch_pc_i;
      w_v_nx        = 1'b0;
`ifdef FETCH_SKID_EN
      w_sk_v_nx     = 1'b0;
`endif
    end else if (bus.stall_i) begin
`ifdef FETCH_SKID_EN
      if (r_ifl_v && !r_sk_v) begin
        w_sk_v_nx    = 1'b1;
        w_sk_inst_nx = bus.imem_data_i;
        w_sk_pc_nx   = r_ifl_pc;
      end
`else
      // Returning word has nowhere to go; drop it and refetch after release.
      if (r_ifl_v) begin
        w_fetch_pc_nx = r_ifl_pc;
      end
`endif
    end else begin
`ifdef FETCH_SKID_EN
      if (r_sk_v) begin
        w_v_nx    = 1'b1;
        w_inst_nx = r_sk_inst;
        w_pc_nx   = r_sk_pc;
        w_sk_v_nx = 1'b0;
      end else
`endif
      begin
        w_v_nx    = r_ifl_v;
        w_inst_nx = bus.imem_data_i;
        w_pc_nx   = r_ifl_pc;
      end
      w_fetch_pc_nx = r_fetch_pc + ADDR'(4);
      w_ifl_v_nx    = 1'b1;
      w_ifl_pc_nx   = r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_ifl_v    <= 1'b0;
      r_ifl_pc   <= '0;
      r_v        <= 1'b0;
      r_inst     <= '0;
      r_pc       <= '0;
`ifdef FETCH_SKID_EN
      r_sk_v     <= 1'b0;
      r_sk_inst  <= '0;
      r_sk_pc    <= '0;
`endif
    end else begin
      r_fetch_pc <= w_fetch_pc_nx;
      r_ifl_v    <= w_ifl_v_nx;
      r_ifl_pc   <= w_ifl_pc_nx;
      r_v        <= w_v_nx;
      r_inst     <= w_inst_nx;
      r_pc       <= w_pc_nx;
`ifdef FETCH_SKID_EN
      r_sk_v     <= w_sk_v_nx;
      r_sk_inst  <= w_sk_inst_nx;
      r_sk_pc    <= w_sk_pc_nx;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_instruction.sv
// Bench for fetch_instruction: directed scenarios with literal expectations plus random stall/branch/reset
// traffic checked every cycle against a queue-based model of fetched-but-undelivered addresses.
module tb_fetch_instruction;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  bit   armed;

  fetch_instruction_if #(.WORD(32), .ADDR(32)) bus ();

  fetch_instruction dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Instruction memory: data for a strobed address appears for the following cycle; otherwise junk.
  always @(posedge clk) begin
    logic        e;
    logic [31:0] a;
    e = bus.imem_en_o;
    a = bus.imem_addr_o;
    #1;
    bus.imem_data_i = e ? memf(a) : $urandom;
  end

  // Reference model: next fetch address, queue of issued-but-undelivered addresses, delivered output.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_v;
  logic [31:0] m_pcout;
  logic [31:0] m_inst;

  always @(posedge clk) begin
    if (reset) begin
      m_pc    = 32'h0;
      m_q.delete();
      m_v     = 1'b0;
      m_pcout = 32'h0;
      m_inst  = 32'h0;
      armed   = 1'b1;
    end else if (bus.branch_i) begin
      m_pc = bus.branch_pc_i;
      m_q.delete();
      m_v  = 1'b0;
    end else if (bus.stall_i) begin
`ifndef FETCH_SKID_EN
      if (m_q.size() > 0) begin
        m_pc = m_q[0];
        m_q.delete();
      end
`endif
    end else begin
      if (m_q.size() > 0) begin
        m_v     = 1'b1;
        m_pcout = m_q.pop_front();
        m_inst  = memf(m_pcout);
      end else begin
        m_v = 1'b0;
      end
      m_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("imem_en", bus.imem_en_o, !reset && !bus.stall_i && !bus.branch_i);
      chk("imem_addr", bus.imem_addr_o, m_pc);
      chk("v_o", bus.v_o, m_v);
      if (m_v) begin
        chk("pc_o", bus.pc_o, m_pcout);
        chk("inst_o", bus.inst_o, m_inst);
      end
    end
  end

  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    reset           = r;
    bus.stall_i     = s;
    bus.branch_i    = b;
    bus.branch_pc_i = t;
    @(negedge clk);
  endtask

  initial begin
    bit found;
    n_tests         = 0;
    n_fail          = 0;
    armed           = 1'b0;
    reset           = 1'b1;
    bus.stall_i     = 1'b0;
    bus.branch_i    = 1'b0;
    bus.branch_pc_i = 32'h0;
    bus.imem_data_i = 32'h0;

    repeat (3) cyc(1, 0, 0, 0);
    chk("rst_v", bus.v_o, 0);
    chk("rst_pc", bus.pc_o, 0);
    chk("rst_inst", bus.inst_o, 0);
    chk("rst_en", bus.imem_en_o, 0);

    cyc(0, 0, 0, 0); chk("c1_addr", bus.imem_addr_o, 32'h0); chk("c1_en", bus.imem_en_o, 1);
    cyc(0, 0, 0, 0); chk("c2_addr", bus.imem_addr_o, 32'h4);
    cyc(0, 0, 0, 0); chk("c3_addr", bus.imem_addr_o, 32'h8);
    chk("c3_v", bus.v_o, 1); chk("c3_pc", bus.pc_o, 32'h0); chk("c3_inst", bus.inst_o, memf(32'h0));
    cyc(0, 0, 0, 0); chk("c4_pc", bus.pc_o, 32'h4);
    cyc(0, 0, 0, 0); chk("c5_pc", bus.pc_o, 32'h8);
    repeat (3) cyc(0, 0, 0, 0);

    cyc(0, 0, 1, 32'h100); chk("br_en", bus.imem_en_o, 0);
    cyc(0, 0, 0, 0); chk("b1_v", bus.v_o, 0); chk("b1_addr", bus.imem_addr_o, 32'h100);
    cyc(0, 0, 0, 0); chk("b2_v", bus.v_o, 0);
    cyc(0, 0, 0, 0); chk("b3_v", bus.v_o, 1); chk("b3_pc", bus.pc_o, 32'h100);
    cyc(0, 0, 0, 0); chk("b4_pc", bus.pc_o, 32'h104);

    cyc(0, 0, 1, 32'h10);
    repeat (2) cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("st_pc", bus.pc_o, 32'h10); chk("st_v", bus.v_o, 1); chk("st_en", bus.imem_en_o, 0);
    end
    cyc(0, 0, 0, 0); chk("r0_pc", bus.pc_o, 32'h10);
`ifdef FETCH_SKID_EN
    chk("r0_addr", bus.imem_addr_o, 32'h18);
    cyc(0, 0, 0, 0); chk("r1_v", bus.v_o, 1); chk("r1_pc", bus.pc_o, 32'h14);
    cyc(0, 0, 0, 0); chk("r2_v", bus.v_o, 1); chk("r2_pc", bus.pc_o, 32'h18);
`else
    chk("r0_addr", bus.imem_addr_o, 32'h14);
    cyc(0, 0, 0, 0); chk("r1_v", bus.v_o, 0);
    cyc(0, 0, 0, 0); chk("r2_v", bus.v_o, 1); chk("r2_pc", bus.pc_o, 32'h14);
`endif

    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h40);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cyc(0, 0, 0, 0);
      if (bus.v_o) begin
        found = 1'b1;
        chk("bs_pc", bus.pc_o, 32'h40);
      end
    end
    chk("bs_found", found, 1);

    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0); chk("wrap_a0", bus.imem_addr_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0); chk("wrap_a1", bus.imem_addr_o, 32'h0);
    repeat (3) cyc(0, 0, 0, 0);

    repeat (2) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0); chk("rs_en", bus.imem_en_o, 0);
    cyc(0, 0, 0, 0); chk("rs_addr", bus.imem_addr_o, 32'h0); chk("rs_v", bus.v_o, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); chk("rs_pc", bus.pc_o, 32'h0); chk("rs_v2", bus.v_o, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      t[1:0] = 2'b00;
      cyc(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 6), t);
    end
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
